alu_req_arbiter: RTL and testbench

//  Shares the single ALU among four requesters (req[3:0]).

---
 rtl/alu_req_arbiter_pkg.sv | 25 ++
 rtl/alu_req_arbiter_priority_encoder.sv | 29 ++
 rtl/alu_req_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_req_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_req_arbiter_pkg.sv
// ============================================================================
// Module : alu_req_arbiter_pkg
// Brief  : Shared types and constants for the ALU request arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_req_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    idx_to_onehot = NUM_REQ'(1) << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_req_arbiter_priority_encoder.sv
// ============================================================================
// Module : priority_encoder
// Brief  : Lowest-set-bit priority encoder with an "any bit set" flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module priority_encoder #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  output logic [W-1:0] o_idx,
  output logic         o_v
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = W'(i);
    end
  end

  assign o_v = |i_req;

endmodule

`default_nettype wire

// File: rtl/alu_req_arbiter.sv
// ============================================================================
// Module : alu_req_arbiter
// Brief  : Shares one ALU among four requesters (fixed or round-robin) with a
//          done/timeout handshake.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_req_arbiter
  import alu_req_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_rr_en,
  input  logic               i_alu_done,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_grant_vld,
  output logic               o_alu_start,
  output logic               o_timeout
);

  arb_state_t         r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [IDX_W-1:0]   r_grant_idx;
  logic               r_grant_vld;
  logic               r_alu_start;
  logic               r_timeout;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic               r_rr_mode;
  logic [CNT_W-1:0]   r_wd_cnt;

  logic [IDX_W-1:0]   w_rot;
  logic [NUM_REQ-1:0] w_rot_req;
  logic [IDX_W-1:0]   w_off;
  logic               w_any;
  logic [IDX_W-1:0]   w_win_idx;
  logic [CNT_W-1:0]   w_wd_inc;
  logic               w_wd_expired;

  // Fixed priority is simply round-robin with the rotation pinned at 0.
  assign w_rot = i_rr_en ? r_rr_ptr : '0;

  always_comb begin
    w_rot_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rot_req[i] = i_req[IDX_W'(i + int'(w_rot))];
    end
  end

  priority_encoder #(
    .N(NUM_REQ),
    .W(IDX_W)
  ) u_prio_enc (
    .i_req(w_rot_req),
    .o_idx(w_off),
    .o_v  (w_any)
  );

  assign w_win_idx    = w_off + w_rot;
  assign w_wd_inc     = r_wd_cnt + CNT_W'(1);
  assign w_wd_expired = (w_wd_inc == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_grant_vld <= 1'b0;
      r_alu_start <= 1'b0;
      r_timeout   <= 1'b0;
      r_rr_ptr    <= '0;
      r_rr_mode   <= 1'b0;
      r_wd_cnt    <= '0;
    end else begin
      r_alu_start <= 1'b0;
      r_timeout   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state     <= ST_ISSUE;
            r_grant     <= idx_to_onehot(w_win_idx);
            r_grant_idx <= w_win_idx;
            r_grant_vld <= 1'b1;
            r_alu_start <= 1'b1;
            r_rr_mode   <= i_rr_en;
          end
        end
        ST_ISSUE: begin
          r_wd_cnt <= '0;
          if (i_alu_done) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_grant_vld <= 1'b0;
            if (r_rr_mode) r_rr_ptr <= r_grant_idx + IDX_W'(1);
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Done takes precedence over an expiring watchdog on the same cycle.
          if (i_alu_done || w_wd_expired) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_grant_vld <= 1'b0;
            r_timeout   <= ~i_alu_done;
            if (r_rr_mode) r_rr_ptr <= r_grant_idx + IDX_W'(1);
          end else begin
            r_wd_cnt <= w_wd_inc;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_grant     = r_grant;
  assign o_grant_idx = r_grant_idx;
  assign o_grant_vld = r_grant_vld;
  assign o_alu_start = r_alu_start;
  assign o_timeout   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
// ============================================================================
// Module : tb_alu_req_arbiter
// Brief  : Directed self-checking bench for alu_req_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_req_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] i_req;
  logic       i_rr_en;
  logic       i_alu_done;
  logic [3:0] o_grant;
  logic [1:0] o_grant_idx;
  logic       o_grant_vld;
  logic       o_alu_start;
  logic       o_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  alu_req_arbiter #(
    .TIMEOUT(15),
    .CNT_W  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_rr_en    (i_rr_en),
    .i_alu_done (i_alu_done),
    .o_grant    (o_grant),
    .o_grant_idx(o_grant_idx),
    .o_grant_vld(o_grant_vld),
    .o_alu_start(o_alu_start),
    .o_timeout  (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".grant"}, 32'(o_grant), 32'h0);
    chk({tag, ".vld"},   32'(o_grant_vld), 32'h0);
    chk({tag, ".start"}, 32'(o_alu_start), 32'h0);
    chk({tag, ".tmo"},   32'(o_timeout), 32'h0);
  endtask

  // Grant from IDLE, done two cycles after the start pulse.
  task automatic do_op(input string tag, input logic [3:0] exp_g, input logic [1:0] exp_i);
    tick();
    chk({tag, ".grant"}, 32'(o_grant), 32'(exp_g));
    chk({tag, ".idx"},   32'(o_grant_idx), 32'(exp_i));
    chk({tag, ".start"}, 32'(o_alu_start), 32'h1);
    tick();
    chk({tag, ".start_1cyc"}, 32'(o_alu_start), 32'h0);
    i_alu_done = 1'b1;
    tick();
    i_alu_done = 1'b0;
    chk({tag, ".rel"}, 32'(o_grant_vld), 32'h0);
  endtask

  initial begin
    int k;
    rst = 1'b1; i_req = 4'b0; i_rr_en = 1'b0; i_alu_done = 1'b0;
    tick(); tick();
    chk("reset.idx", 32'(o_grant_idx), 32'h0);
    chk_idle_outputs("reset");
    rst = 1'b0;
    tick(); tick();
    chk_idle_outputs("noreq");

    // Fixed priority, req=1110 -> requester 1; re-grant after one idle gap.
    i_req = 4'b1110;
    tick();
    chk("fix.grant", 32'(o_grant), 32'h2);
    chk("fix.idx",   32'(o_grant_idx), 32'h1);
    chk("fix.start", 32'(o_alu_start), 32'h1);
    tick();
    chk("fix.start_1cyc", 32'(o_alu_start), 32'h0);
    chk("fix.hold", 32'(o_grant), 32'h2);
    tick();
    i_alu_done = 1'b1;
    tick();
    i_alu_done = 1'b0;
    chk("fix.rel_grant", 32'(o_grant), 32'h0);
    chk("fix.rel_vld",   32'(o_grant_vld), 32'h0);
    chk("fix.idx_kept",  32'(o_grant_idx), 32'h1);
    tick();
    chk("fix.regrant", 32'(o_grant), 32'h2);
    i_req = 4'b0;
    tick();
    i_alu_done = 1'b1;
    tick();
    i_alu_done = 1'b0;
    chk("fix.rel2", 32'(o_grant), 32'h0);

    // Round-robin rotation with all requesters active.
    i_rr_en = 1'b1;
    i_req = 4'b1111;
    do_op("rr0", 4'b0001, 2'd0);
    do_op("rr1", 4'b0010, 2'd1);
    do_op("rr2", 4'b0100, 2'd2);
    do_op("rr3", 4'b1000, 2'd3);
    do_op("rr4", 4'b0001, 2'd0);

    // rr_ptr=3 with req=0101 wraps to requester 0, leaving rr_ptr=1.
    i_req = 4'b0100;
    do_op("rrp3", 4'b0100, 2'd2);
    i_req = 4'b0101;
    do_op("wrap", 4'b0001, 2'd0);
    do_op("ptr1", 4'b0100, 2'd2);

    // Watchdog: no done, requester drops its req after launch.
    i_rr_en = 1'b0;
    i_req = 4'b1000;
    tick();
    chk("tmo.grant", 32'(o_grant), 32'h8);
    i_req = 4'b0;
    i_rr_en = 1'b1;
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (o_timeout) begin
        k = c;
        break;
      end
      if (c == 15) chk("tmo.held15", 32'(o_grant), 32'h8);
    end
    chk("tmo.cycles", 32'(k), 32'd16);
    chk("tmo.grant_drop", 32'(o_grant_vld), 32'h0);
    tick();
    chk("tmo.pulse_1cyc", 32'(o_timeout), 32'h0);

    // Done on the cycle the watchdog would expire: no timeout pulse.
    i_rr_en = 1'b0;
    i_req = 4'b0010;
    tick();
    i_req = 4'b0;
    chk("race.grant", 32'(o_grant), 32'h2);
    for (int c = 1; c <= 15; c++) tick();
    chk("race.held", 32'(o_grant), 32'h2);
    chk("race.no_early_tmo", 32'(o_timeout), 32'h0);
    i_alu_done = 1'b1;
    tick();
    i_alu_done = 1'b0;
    chk("race.tmo", 32'(o_timeout), 32'h0);
    chk("race.rel", 32'(o_grant_vld), 32'h0);
    tick();
    chk("race.tmo_after", 32'(o_timeout), 32'h0);

    // Asynchronous reset in the middle of WAIT.
    i_req = 4'b0100;
    tick(); tick(); tick();
    chk("arst.pre", 32'(o_grant), 32'h4);
    #2 rst = 1'b1;
    #1;
    chk("arst.idx", 32'(o_grant_idx), 32'h0);
    chk_idle_outputs("arst");
    i_req = 4'b0001;
    tick();
    rst = 1'b0;
    i_rr_en = 1'b1;
    i_req = 4'b1111;
    do_op("post_rst", 4'b0001, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
